store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 34 +++
 rtl/store_align.sv | 27 ++
 rtl/store_unit.sv | 134 +++++++++++++
 tb/tb_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, store FSM states and
// the byte-mask helper used by the store alignment path.
package lsu_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } store_state_e;

  // Right-justified byte mask of a store; zero marks an unsupported funct3.
  function automatic logic [3:0] store_byte_mask(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return 4'b0001;
      F3_SH:   return 4'b0011;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] mask_to_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane alignment: places store data and byte enables into a
// two-word window starting at the word containing the store address.
module store_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [63:0] data64,
  output logic [7:0]  be8,
  output logic        split,
  output logic        err
);

  logic [3:0]  mask;
  logic [31:0] data_trunc;

  assign mask = store_byte_mask(funct3);

  // Bytes above the access size are cleared so they never leak into lanes.
  assign data_trunc = wdata & mask_to_bits(mask);
  assign data64     = {32'b0, data_trunc} << {off, 3'b000};
  assign be8        = {4'b0, mask} << off;
  assign split      = |be8[7:4];
  assign err        = (mask == 4'b0000);

endmodule

// File: rtl/store_unit.sv
// RV32I store path: accepts one SB/SH/SW at any byte address and issues one
// or two word-aligned write beats, the second when the store crosses a word.
module store_unit
  import lsu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_addr,
  input  logic [2:0]   i_funct3,
  input  logic [31:0]  i_wdata,
  output logic         o_mem_valid,
  input  logic         i_mem_ready,
  output logic [31:0]  o_mem_addr,
  output logic [31:0]  o_mem_wdata,
  output logic [3:0]   o_mem_be,
  output logic         o_done,
  output logic         o_err,
  output store_state_e o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the beat outputs stay frozen
  // while o_mem_valid is high and i_mem_ready is low.

  store_state_e state, state_next;

  logic [63:0] al_data64;
  logic [7:0]  al_be8;
  logic        al_split;
  logic        al_err;

  logic [31:0] hi_wdata_q;
  logic [3:0]  hi_be_q;
  logic        split_q;

  logic        load_beat0;
  logic        load_beat1;
  logic        finish;
  logic        err_set;

  store_align u_align (
    .off    (i_addr[1:0]),
    .funct3 (i_funct3),
    .wdata  (i_wdata),
    .data64 (al_data64),
    .be8    (al_be8),
    .split  (al_split),
    .err    (al_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_beat0 = 1'b0;
    load_beat1 = 1'b0;
    finish     = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          if (al_err) begin
            err_set = 1'b1;
          end else begin
            load_beat0 = 1'b1;
            state_next = ST_BEAT0;
          end
        end
      end
      ST_BEAT0: begin
        if (i_mem_ready) begin
          if (split_q) begin
            load_beat1 = 1'b1;
            state_next = ST_BEAT1;
          end else begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BEAT1: begin
        if (i_mem_ready) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat registers: beat0 loads at accept, the upper half is parked for beat1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_addr  <= 32'h0;
      o_mem_wdata <= 32'h0;
      o_mem_be    <= 4'h0;
      hi_wdata_q  <= 32'h0;
      hi_be_q     <= 4'h0;
      split_q     <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_done <= finish;
      o_err  <= err_set;
      if (load_beat0) begin
        o_mem_addr  <= {i_addr[31:2], 2'b00};
        o_mem_wdata <= al_data64[31:0];
        o_mem_be    <= al_be8[3:0];
        hi_wdata_q  <= al_data64[63:32];
        hi_be_q     <= al_be8[7:4];
        split_q     <= al_split;
      end else if (load_beat1) begin
        o_mem_addr  <= o_mem_addr + 32'd4;
        o_mem_wdata <= hi_wdata_q;
        o_mem_be    <= hi_be_q;
      end else if (finish) begin
        o_mem_be <= 4'h0;
      end
    end
  end

  assign o_ready     = (state == ST_IDLE);
  assign o_mem_valid = (state != ST_IDLE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_store_unit.sv
// Directed plus randomized bench for store_unit with a beat scoreboard.
module tb_store_unit;
  import lsu_pkg::*;

  logic         i_clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_addr;
  logic [2:0]   i_funct3;
  logic [31:0]  i_wdata;
  logic         o_mem_valid;
  logic         i_mem_ready;
  logic [31:0]  o_mem_addr;
  logic [31:0]  o_mem_wdata;
  logic [3:0]   o_mem_be;
  logic         o_done;
  logic         o_err;
  store_state_e o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  logic [67:0] exp_q[$];

  store_unit dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_addr      (i_addr),
    .i_funct3    (i_funct3),
    .i_wdata     (i_wdata),
    .o_mem_valid (o_mem_valid),
    .i_mem_ready (i_mem_ready),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-by-byte reference model of the beats a store should produce.
  task automatic push_expected(input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] data, output int done_cyc);
    int n;
    int p;
    logic [31:0] base;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [3:0]  b0;
    logic [3:0]  b1;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
    base = {addr[31:2], 2'b00};
    w0 = '0; w1 = '0; b0 = '0; b1 = '0;
    for (int k = 0; k < n; k++) begin
      p = int'(addr[1:0]) + k;
      if (p < 4) begin
        w0[8*p +: 8] = data[8*k +: 8];
        b0[p] = 1'b1;
      end else begin
        w1[8*(p-4) +: 8] = data[8*k +: 8];
        b1[p-4] = 1'b1;
      end
    end
    if (n > 0) exp_q.push_back({base, w0, b0});
    if (b1 != 4'b0) exp_q.push_back({base + 32'd4, w1, b1});
    done_cyc = (n == 0) ? 0 : (b1 != 4'b0) ? 3 : 2;
  endtask

  // driver: returns #1 into the cycle after the accept edge (T+1)
  task automatic send_store(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data, output int done_cyc);
    @(posedge i_clk); #1;
    i_valid  = 1'b1;
    i_addr   = addr;
    i_funct3 = f3;
    i_wdata  = data;
    push_expected(addr, f3, data, done_cyc);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Waits for o_done; cycles are numbered with the accept cycle as 0.
  task automatic wait_done(input int exp_cyc, input int start_cyc, input string tag);
    int cyc;
    bit got;
    cyc = start_cyc;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        got = 1'b1;
      end else begin
        check({tag, "_err_quiet"}, o_err, 1'b0);
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    check({tag, "_done_cycle"}, got ? cyc : 0, exp_cyc);
    if (got) check({tag, "_done_ready"}, o_ready, 1'b1);
  endtask

  // scoreboard monitor: compares every presented beat, pops on handshake
  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      if (o_mem_valid === 1'b1) begin
        check("ready_busy", o_ready, 1'b0);
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL beat_unexpected: observed %h/%h/%b expected none",
                 o_mem_addr, o_mem_wdata, o_mem_be);
        end
        if (exp_q.size() != 0) begin
          check("beat", {o_mem_addr, o_mem_wdata, o_mem_be}, exp_q[0]);
          if (i_mem_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("be_idle", o_mem_be, 4'b0);
      end
    end
  end

  initial begin
    int ec;
    int ec2;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [2:0]  rf;

    i_rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_funct3 = '0;
    i_wdata = '0; i_mem_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_mem_valid", o_mem_valid, 1'b0);
    check("rst_addr", o_mem_addr, 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    check("rst_be", o_mem_be, 4'h0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_state", o_dbg_state, ST_IDLE);
    mon_en = 1'b1;

    // aligned word
    send_store(32'h0000_0100, F3_SW, 32'hDEAD_BEEF, ec);
    wait_done(ec, 1, "sw_aligned");

    // byte in the top lane
    send_store(32'h0000_0103, F3_SB, 32'h0000_00A5, ec);
    wait_done(ec, 1, "sb_lane3");

    // halfword crossing a word boundary
    send_store(32'h0000_0103, F3_SH, 32'h0000_1234, ec);
    wait_done(ec, 1, "sh_split");

    // split word with three stall cycles on each beat
    i_mem_ready = 1'b0;
    send_store(32'h0000_0102, F3_SW, 32'h1122_3344, ec);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("stall_state_b0", o_dbg_state, ST_BEAT0);
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0;
    @(negedge i_clk);
    check("stall_state_b1", o_dbg_state, ST_BEAT1);
    repeat (3) @(posedge i_clk);
    #1 i_mem_ready = 1'b1;
    wait_done(9, 8, "sw_stall");

    // split word at the top of memory, reset during the beat1 stall
    send_store(32'hFFFF_FFFE, F3_SW, 32'hCAFE_BABE, ec);
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    check("midrst_mem_valid", o_mem_valid, 1'b0);
    check("midrst_ready", o_ready, 1'b1);
    check("midrst_be", o_mem_be, 4'h0);
    check("midrst_state", o_dbg_state, ST_IDLE);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_done", o_done, 1'b0);
      @(negedge i_clk);
    end
    i_mem_ready = 1'b1;

    // unsupported funct3: error pulse only
    send_store(32'h0000_0200, 3'b011, 32'h5555_5555, ec);
    @(negedge i_clk);
    check("err_pulse", o_err, 1'b1);
    check("err_no_done", o_done, 1'b0);
    check("err_no_beat", o_mem_valid, 1'b0);
    check("err_ready", o_ready, 1'b1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("err_single", o_err, 1'b0);
    check("err_no_done2", o_done, 1'b0);

    // back-to-back: next store accepted in the o_done cycle
    send_store(32'h0000_0103, F3_SB, 32'h0000_00A5, ec);
    wait_done(ec, 1, "b2b_first");
    i_valid  = 1'b1;
    i_addr   = 32'h0000_0201;
    i_funct3 = F3_SB;
    i_wdata  = 32'hFFFF_FF5A;
    push_expected(i_addr, i_funct3, i_wdata, ec2);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_done(ec2, 1, "b2b_second");

    // random stores
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rd = $urandom;
      rf = 3'($urandom_range(0, 2));
      send_store(ra, rf, rd, ec);
      wait_done(ec, 1, "rand");
    end

    repeat (2) @(posedge i_clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
